// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM state encoding, the read-return tag and the saturating counter helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic idx;
    } rd_tag_t;

    localparam int          RD_LAT_MAX = 4;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, requester} for each outstanding read.
// The exit stage lines up with the cycle the memory presents the read data.
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    any_valid
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter with burst locking in front of the data memory.
// Optional grant/conflict counters are built when DMEM_ARB_PERF_EN is defined.
//
// state | meaning
// IDLE  | no owner, round-robin between requesters
// OWN0  | port 0 holds the memory across a locked burst
// OWN1  | port 1 holds the memory across a locked burst
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       m0_gnt_cnt,
    output logic [15:0]       m1_gnt_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       issue, sel_wr;
    rd_tag_t    tag_push, tag_pop;
    logic       tags_busy;

    // Grants are suppressed while reset is held so no strobe leaks out.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last_q;
                        m1_gnt = ~last_q;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    assign issue  = m0_gnt | m1_gnt;
    assign sel_wr = m1_gnt ? m1_wr : m0_wr;

    always_comb begin
        mem_wr    = issue & sel_wr;
        mem_rd    = issue & ~sel_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = issue ? m1_gnt : last_q;
        case (state_q)
            IDLE: begin
                if (m0_gnt && m0_lock)      state_d = OWN0;
                else if (m1_gnt && m1_lock) state_d = OWN1;
            end
            OWN0: if (!m0_req || (m0_gnt && !m0_lock)) state_d = IDLE;
            OWN1: if (!m1_req || (m1_gnt && !m1_lock)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign tag_push.valid = issue & ~sel_wr;
    assign tag_push.idx   = m1_gnt;

    dmem_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst_n     (reset),
        .tag_in    (tag_push),
        .tag_out   (tag_pop),
        .any_valid (tags_busy)
    );

    assign m0_rvalid = tag_pop.valid & ~tag_pop.idx;
    assign m1_rvalid = tag_pop.valid &  tag_pop.idx;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
    assign busy      = tags_busy | (state_q != IDLE);

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] m0_cnt_q, m0_cnt_d;
    logic [15:0] m1_cnt_q, m1_cnt_d;
    logic [15:0] cfl_cnt_q, cfl_cnt_d;

    always_comb begin
        m0_cnt_d  = sat_inc(m0_cnt_q, m0_gnt);
        m1_cnt_d  = sat_inc(m1_cnt_q, m1_gnt);
        cfl_cnt_d = sat_inc(cfl_cnt_q, m0_req & m1_req);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_cnt_q  <= '0;
            m1_cnt_q  <= '0;
            cfl_cnt_q <= '0;
        end else begin
            m0_cnt_q  <= m0_cnt_d;
            m1_cnt_q  <= m1_cnt_d;
            cfl_cnt_q <= cfl_cnt_d;
        end
    end

    assign m0_gnt_cnt   = m0_cnt_q;
    assign m1_gnt_cnt   = m1_cnt_q;
    assign conflict_cnt = cfl_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a transaction-level reference model.
// Counter checks are included when DMEM_ARB_PERF_EN is defined.
module tb_dmem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_wr, mem_rd, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   m0_gnt_cnt, m1_gnt_cnt, conflict_cnt;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_PERF_EN
        , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    function automatic logic [DW-1:0] mem_init_val(input int a);
        return 32'hC0DE0000 | DW'(a);
    endfunction

    // Memory with LAT-cycle read latency; junk on the bus when no read returns.
    logic [DW-1:0] mem [512];
    logic          mem_written [512];
    logic [DW-1:0] mpipe [LAT];
    assign mem_rdata = mpipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
        if (mem_rd)
            mpipe[0] <= (mem_written[mem_addr] === 1'b1) ? mem[mem_addr] : mem_init_val(int'(mem_addr));
        else
            mpipe[0] <= 32'hBAD00000 ^ $urandom;
        if (mem_wr) begin
            mem[mem_addr]         <= mem_wdata;
            mem_written[mem_addr] <= 1'b1;
        end
    end

    // Reference model: owner of a locked burst, last winner, pending returns.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] refmem [512];
    int            owner;
    logic          last;
    int            cyc;
    int            m_g0, m_g1, m_cf;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        owner = -1;
        last  = 1'b1;
        m_g0  = 0;
        m_g1  = 0;
        m_cf  = 0;
    endtask

    task automatic tick();
        logic          g0, g1, iss, sel, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd0, rd1;
        logic          rv0, rv1, eb;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset) begin
            if (owner == 0)      g0 = m0_req;
            else if (owner == 1) g1 = m1_req;
            else if (m0_req && m1_req) begin
                g0 = (last == 1'b1);
                g1 = !g0;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
        iss = g0 | g1;
        sel = g1;
        wr  = sel ? m1_wr : m0_wr;
        a   = !iss ? '0 : (sel ? m1_addr : m0_addr);
        d   = !iss ? '0 : (sel ? m1_wdata : m0_wdata);
        rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].port == 0) begin rv0 = 1'b1; rd0 = rq[0].data; end
            else                 begin rv1 = 1'b1; rd1 = rq[0].data; end
        end
        eb = (owner != -1) || (rq.size() > 0);

        check_eq("m0_gnt", m0_gnt, g0);
        check_eq("m1_gnt", m1_gnt, g1);
        check_eq("mem_wr", mem_wr, iss & wr);
        check_eq("mem_rd", mem_rd, iss & ~wr);
        check_eq("mem_addr", mem_addr, a);
        check_eq("mem_wdata", mem_wdata, d);
        check_eq("m0_rvalid", m0_rvalid, rv0);
        check_eq("m1_rvalid", m1_rvalid, rv1);
        check_eq("m0_rdata", m0_rdata, rd0);
        check_eq("m1_rdata", m1_rdata, rd1);
        check_eq("busy", busy, eb);
`ifdef DMEM_ARB_PERF_EN
        check_eq("m0_gnt_cnt", m0_gnt_cnt, m_g0);
        check_eq("m1_gnt_cnt", m1_gnt_cnt, m_g1);
        check_eq("conflict_cnt", conflict_cnt, m_cf);
`endif

        if (reset) begin
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            if (iss && !wr) rq.push_back('{due: cyc + LAT, port: int'(sel), data: refmem[a]});
            if (iss && wr)  refmem[a] = d;
            if (owner == -1) begin
                if (g0 && m0_lock)      owner = 0;
                else if (g1 && m1_lock) owner = 1;
            end else if (owner == 0) begin
                if (!m0_req || (g0 && !m0_lock)) owner = -1;
            end else begin
                if (!m1_req || (g1 && !m1_lock)) owner = -1;
            end
            if (iss) last = sel;
            if (g0 && m_g0 < 65535) m_g0++;
            if (g1 && m_g1 < 65535) m_g1++;
            if (m0_req && m1_req && m_cf < 65535) m_cf++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_m0(input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = r; m0_wr = w; m0_lock = l; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = r; m1_wr = w; m1_lock = l; m1_addr = a; m1_wdata = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 512; i++) refmem[i] = mem_init_val(i);
        model_reset();
        set_m0(0, 0, 0, '0, '0);
        set_m1(0, 0, 0, '0, '0);
        reset = 1'b0;
        repeat (2) tick();
        #1 reset = 1'b1;
        tick();

        // write DEADBEEF then read it back on port 0
        set_m0(1, 1, 0, 9'h010, 32'hDEADBEEF); tick();
        set_m0(1, 0, 0, 9'h010, '0);           tick();
        set_m0(0, 0, 0, '0, '0);
        repeat (LAT + 1) tick();

        // dual requests without lock alternate
        for (int i = 0; i < 4; i++) begin
            set_m0(1, 1, 0, 9'(i), $urandom);
            set_m1(1, 1, 0, 9'(i + 8), $urandom);
            tick();
        end

        // port 1 locked burst of three writes while port 0 waits
        set_m0(1, 0, 0, 9'h005, '0);
        for (int i = 0; i < 3; i++) begin
            set_m1(1, 1, 1, 9'(i + 32), $urandom);
            tick();
        end
        set_m1(0, 0, 0, '0, '0);
        repeat (2) tick();
        set_m0(0, 0, 0, '0, '0);
        tick();

        // alternating back-to-back reads
        set_m0(1, 0, 0, 9'h004, '0); tick();
        set_m0(0, 0, 0, '0, '0);
        set_m1(1, 0, 0, 9'h008, '0); tick();
        set_m1(0, 0, 0, '0, '0);
        repeat (LAT + 1) tick();

        // reset one cycle after a read issues drops the return
        set_m0(1, 0, 0, 9'h010, '0); tick();
        set_m0(0, 0, 0, '0, '0);
        pulse_reset();
        repeat (LAT + 2) tick();

        // five conflict cycles straight after reset
        pulse_reset();
        set_m0(1, 1, 0, 9'h020, $urandom);
        set_m1(1, 1, 0, 9'h021, $urandom);
        repeat (5) tick();
        set_m0(0, 0, 0, '0, '0);
        set_m1(0, 0, 0, '0, '0);
`ifdef DMEM_ARB_PERF_EN
        check_eq("perf_conflict5", conflict_cnt, 32'd5);
        check_eq("perf_m0_3", m0_gnt_cnt, 32'd3);
        check_eq("perf_m1_2", m1_gnt_cnt, 32'd2);
`endif
        tick();

        for (int n = 0; n < 3000; n++) begin
            set_m0($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 9) < 3, 9'($urandom_range(0, 15)), $urandom);
            set_m1($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 9) < 3, 9'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else tick();
        end
        set_m0(0, 0, 0, '0, '0);
        set_m1(0, 0, 0, '0, '0);
        repeat (LAT + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
